event_readout: RTL and testbench

EVENT_READOUT -- requirements
Module: event_readout

---
 rtl/event_pkg.sv | 29 ++
 rtl/sample_ring.sv | 51 +++++
 rtl/event_readout.sv | 214 +++++++++++++++++++++
 tb/tb_event_readout.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// ---------------------------------------------------------------------------
// event_pkg
// Shared definitions for the event readout block.
//   state_t          : readout FSM encoding (FILL, ARMED, POST, DRAIN)
//   DEF_*            : default geometry of one event window
//   EVENT_LEN        : beats per event for the default geometry
//   event_len()      : beats per event for any PRE/POST pair
// ---------------------------------------------------------------------------
package event_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_MAX_SAMPLES  = 16;
  localparam int DEF_PRE_SAMPLES  = 4;
  localparam int DEF_POST_SAMPLES = 8;

  // One event = pre-trigger history, the trigger sample, post-trigger tail.
  localparam int EVENT_LEN = DEF_PRE_SAMPLES + 1 + DEF_POST_SAMPLES;

  function automatic int event_len(input int pre, input int post);
    return pre + 1 + post;
  endfunction

endpackage

// File: rtl/sample_ring.sv
// ---------------------------------------------------------------------------
// sample_ring
// Simple dual-port sample store: one write port, one registered read port
// with read enable. Written so synthesis maps it onto block RAM.
//   clk_i    : clock, rising edge
//   rst_ni   : synchronous active-low reset (clears the read register only)
//   we_i     : write strobe
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; read register updates only when high
//   raddr_i  : read address
//   rdata_o  : registered read data, holds while re_i is low
// ---------------------------------------------------------------------------
module sample_ring #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 14
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Storage itself is never reset so it stays a plain RAM array.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register: the hold-while-disabled behaviour is what lets the
  // readout stall the stream without an extra skid buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/event_readout.sv
// ---------------------------------------------------------------------------
// event_readout
// Captures a stream of ADC samples into a ring, detects a rising threshold
// crossing, keeps PRE_SAMPLES of history plus POST_SAMPLES of tail, then
// streams the whole event out over a valid/ready port.
//   clk_i         : clock, rising edge
//   rst_ni        : synchronous active-low reset
//   data_i        : unsigned ADC sample
//   data_valid_i  : data_i carries a sample this cycle
//   threshold_i   : unsigned trigger level
//   arm_i         : level, trigger search permitted while high
//   out_data_o    : event sample stream
//   out_valid_o   : out_data_o is valid
//   out_ready_i   : downstream accepts a beat
//   out_last_o    : final beat of the event
//   busy_o        : event in progress (POST or DRAIN)
//   overrun_o     : sticky, a sample was dropped while draining
//   state_o       : current FSM state (debug)
//
// Output handshake: a beat transfers on a rising edge where out_valid_o and
// out_ready_i are both high. Once out_valid_o is raised, out_data_o,
// out_valid_o and out_last_o stay unchanged until that transfer happens.
// ---------------------------------------------------------------------------
module event_readout
  import event_pkg::*;
#(
  parameter int MAX_SAMPLES  = DEF_MAX_SAMPLES,
  parameter int ADDR_BITS    = $clog2(MAX_SAMPLES),
  parameter int DWIDTH       = 14,
  parameter int PRE_SAMPLES  = DEF_PRE_SAMPLES,
  parameter int POST_SAMPLES = DEF_POST_SAMPLES
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              data_valid_i,
  input  logic [DWIDTH-1:0] threshold_i,
  input  logic              arm_i,
  output logic [DWIDTH-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              overrun_o,
  output state_t            state_o
);

  localparam int EVT_LEN = event_len(PRE_SAMPLES, POST_SAMPLES);
  localparam int CNT_W   = $clog2(MAX_SAMPLES + 1);

  localparam logic [CNT_W-1:0]     PRE_CNT   = CNT_W'(PRE_SAMPLES);
  localparam logic [CNT_W-1:0]     POST_CNT  = CNT_W'(POST_SAMPLES);
  localparam logic [CNT_W-1:0]     EVT_CNT   = CNT_W'(EVT_LEN);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(MAX_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] PRE_ADDR  = ADDR_BITS'(PRE_SAMPLES);
  localparam logic [ADDR_BITS-1:0] WRAP_OFS  = ADDR_BITS'(MAX_SAMPLES - PRE_SAMPLES);

  // An event window larger than the ring would overwrite its own history.
  if (EVT_LEN > MAX_SAMPLES) begin : g_bad_geometry
    $error("event_readout: PRE_SAMPLES+1+POST_SAMPLES exceeds MAX_SAMPLES");
  end

  // Ring addresses wrap at MAX_SAMPLES, which need not be a power of two.
  function automatic logic [ADDR_BITS-1:0] addr_inc(input logic [ADDR_BITS-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_BITS'(1);
  endfunction

  // First address of the event window: trigger address minus the history
  // depth, modulo the ring size.
  function automatic logic [ADDR_BITS-1:0] win_start(input logic [ADDR_BITS-1:0] t);
    return (t >= PRE_ADDR) ? t - PRE_ADDR : t + WRAP_OFS;
  endfunction

  state_t              state_q;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [ADDR_BITS-1:0] rd_addr_q;
  logic [ADDR_BITS-1:0] trig_addr_q;
  logic [CNT_W-1:0]     fill_cnt_q;
  logic [CNT_W-1:0]     post_cnt_q;
  logic [CNT_W-1:0]     rd_cnt_q;
  logic [DWIDTH-1:0]    prev_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 overrun_q;

  logic wr_en;
  logic trig_hit;
  logic rd_en;
  logic beat_done;

  // Writes are frozen while draining so the window being read stays intact.
  assign wr_en = data_valid_i && (state_q != ST_DRAIN);

  // Rising crossing only: the previously written sample must be below the
  // level, so a signal parked above threshold never retriggers.
  assign trig_hit = (state_q == ST_ARMED) && arm_i && data_valid_i &&
                    (prev_q < threshold_i) && (data_i >= threshold_i);

  // Issue a read when the output register is empty or is being emptied in
  // this same cycle; this gives one beat per cycle under continuous ready.
  assign rd_en = (state_q == ST_DRAIN) && (rd_cnt_q != EVT_CNT) &&
                 (!out_valid_q || out_ready_i);

  assign beat_done = out_valid_q && out_ready_i;

  sample_ring #(
    .DEPTH (MAX_SAMPLES),
    .AW    (ADDR_BITS),
    .DW    (DWIDTH)
  ) u_ring (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (wr_en),
    .waddr_i (wr_addr_q),
    .wdata_i (data_i),
    .re_i    (rd_en),
    .raddr_i (rd_addr_q),
    .rdata_o (out_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_FILL;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      trig_addr_q <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_addr_q <= addr_inc(wr_addr_q);
        prev_q    <= data_i;
      end

      case (state_q)
        ST_FILL: begin
          // Gather enough history before a trigger may be accepted.
          if (data_valid_i) begin
            fill_cnt_q <= fill_cnt_q + CNT_ONE;
            if (fill_cnt_q + CNT_ONE >= PRE_CNT) begin
              state_q <= ST_ARMED;
            end
          end
        end

        ST_ARMED: begin
          if (trig_hit) begin
            trig_addr_q <= wr_addr_q;
            post_cnt_q  <= '0;
            busy_q      <= 1'b1;
            if (POST_SAMPLES == 0) begin
              state_q   <= ST_DRAIN;
              rd_addr_q <= win_start(wr_addr_q);
              rd_cnt_q  <= '0;
            end else begin
              state_q <= ST_POST;
            end
          end
        end

        ST_POST: begin
          if (data_valid_i) begin
            post_cnt_q <= post_cnt_q + CNT_ONE;
            if (post_cnt_q + CNT_ONE == POST_CNT) begin
              state_q   <= ST_DRAIN;
              rd_addr_q <= win_start(trig_addr_q);
              rd_cnt_q  <= '0;
            end
          end
        end

        ST_DRAIN: begin
          if (data_valid_i) begin
            overrun_q <= 1'b1;
          end
          if (rd_en) begin
            rd_addr_q   <= addr_inc(rd_addr_q);
            rd_cnt_q    <= rd_cnt_q + CNT_ONE;
            out_valid_q <= 1'b1;
            out_last_q  <= (rd_cnt_q == EVT_CNT - CNT_ONE);
          end else if (beat_done) begin
            // Only reached once every read is issued: the final beat.
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q    <= ST_FILL;
              fill_cnt_q <= '0;
              busy_q     <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign overrun_o   = overrun_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_event_readout.sv
// ---------------------------------------------------------------------------
// tb_event_readout
// Directed bench for event_readout with default geometry
// (MAX=16, PRE=4, POST=8, DWIDTH=14). Inputs change and outputs are sampled
// on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_event_readout;
  import event_pkg::*;

  localparam int DW      = 14;
  localparam int EVT_LEN = 13;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          data_valid;
  logic [DW-1:0] threshold;
  logic          arm;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          overrun;
  state_t        dbg_state;

  int n_total;
  int n_bad;

  logic [DW-1:0] exp_q[$];

  event_readout #(
    .MAX_SAMPLES  (16),
    .DWIDTH       (DW),
    .PRE_SAMPLES  (4),
    .POST_SAMPLES (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_i       (data_in),
    .data_valid_i (data_valid),
    .threshold_i  (threshold),
    .arm_i        (arm),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_last_o   (out_last),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .state_o      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    out_ready  = 1'b0;
    arm        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- drivers ----------------
  // One valid sample for exactly one clock cycle.
  task automatic drive(input int v, input bit a);
    data_in    = DW'(v);
    data_valid = 1'b1;
    arm        = a;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  // Ramp 0,10,...,180: trigger at 100, window 60..180.
  task automatic ramp_event();
    for (int k = 0; k < 19; k++) drive(k * 10, 1'b1);
    for (int k = 6; k < 19; k++) exp_q.push_back(DW'(k * 10));
  endtask

  // Collect n beats from the output, comparing against exp_q. Returns at the
  // falling edge where the last counted beat is presented with ready high.
  task automatic collect(input int n, input bit toggle, input bit hold_valid, input string tag);
    int            got;
    int            cyc;
    bit            stall;
    bit            rdy;
    logic [DW-1:0] sd;
    logic          sl;
    logic [DW-1:0] e;
    got   = 0;
    cyc   = 0;
    stall = 1'b0;
    while (got < n && cyc < 300) begin
      if (stall) begin
        check({tag, "_stall_data"}, 32'(out_data), 32'(sd));
        check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_stall_last"}, 32'(out_last), 32'(sl));
      end
      rdy        = toggle ? (cyc % 2 == 0) : 1'b1;
      out_ready  = rdy;
      data_valid = hold_valid;
      data_in    = DW'(999);
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, 32'(out_data), 32'hFFFF_FFFF);
          e = '0;
        end else begin
          e = exp_q.pop_front();
        end
        check({tag, "_data"}, 32'(out_data), 32'(e));
        check({tag, "_last"}, 32'(out_last), (got == EVT_LEN - 1) ? 32'd1 : 32'd0);
        got++;
        stall = 1'b0;
      end else begin
        stall = out_valid;
        sd    = out_data;
        sl    = out_last;
      end
      cyc++;
      if (got < n) @(negedge clk);
    end
    data_valid = 1'b0;
    if (got < n) check({tag, "_timeout_beats"}, 32'(got), 32'(n));
  endtask

  // After the final handshake: stream stops, FSM back in FILL.
  task automatic check_done(input string tag);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_state_fill"}, 32'(dbg_state), 32'(ST_FILL));
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    n_total   = 0;
    n_bad     = 0;
    threshold = DW'(100);
    rst_n     = 1'b0;
    data_valid = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    arm       = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_FILL));
    rst_n = 1'b1;

    // Basic ramp, ready always high.
    ramp_event();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_state_drain", 32'(dbg_state), 32'(ST_DRAIN));
    collect(EVT_LEN, 1'b0, 1'b0, "t1");
    check_done("t1");
    check("t1_overrun", 32'(overrun), 32'd0);

    // No reset: write pointer sits at 3, 14 pre-trigger samples put the
    // trigger at address 1, so the window wraps 13,14,15,0,...
    for (int k = 0; k < 14; k++) drive(k * 5, 1'b1);
    check("t3_no_trig", 32'(busy), 32'd0);
    drive(150, 1'b1);
    check("t3_trig_state", 32'(dbg_state), 32'(ST_POST));
    for (int k = 1; k <= 8; k++) drive(150 + k, 1'b1);
    exp_q = '{DW'(50), DW'(55), DW'(60), DW'(65), DW'(150), DW'(151), DW'(152),
              DW'(153), DW'(154), DW'(155), DW'(156), DW'(157), DW'(158)};
    collect(EVT_LEN, 1'b0, 1'b0, "t3");
    check_done("t3");

    // Ready toggling every cycle.
    do_reset();
    ramp_event();
    collect(EVT_LEN, 1'b1, 1'b0, "t2");
    check_done("t2");

    // Crossing in FILL ignored, crossing with ARM low ignored, parked above
    // threshold ignored, then a genuine crossing; ARM low through POST/DRAIN.
    do_reset();
    drive(0, 1'b1);
    drive(150, 1'b1);
    drive(0, 1'b1);
    drive(10, 1'b1);
    check("t4_fill_cross", 32'(busy), 32'd0);
    check("t4_armed", 32'(dbg_state), 32'(ST_ARMED));
    drive(40, 1'b0);
    drive(100, 1'b0);
    check("t4_arm_low", 32'(busy), 32'd0);
    drive(120, 1'b1);
    drive(120, 1'b1);
    drive(120, 1'b1);
    check("t4_parked_high", 32'(busy), 32'd0);
    drive(50, 1'b1);
    drive(110, 1'b1);
    check("t4_trig", 32'(dbg_state), 32'(ST_POST));
    for (int k = 1; k <= 8; k++) drive(110 + k, 1'b0);
    check("t4_post_noabort", 32'(dbg_state), 32'(ST_DRAIN));
    exp_q = '{DW'(120), DW'(120), DW'(120), DW'(50), DW'(110), DW'(111), DW'(112),
              DW'(113), DW'(114), DW'(115), DW'(116), DW'(117), DW'(118)};
    collect(EVT_LEN, 1'b0, 1'b0, "t4");
    check_done("t4");
    arm = 1'b1;

    // Samples arriving during DRAIN are dropped and flag overrun, sticky.
    do_reset();
    ramp_event();
    collect(EVT_LEN, 1'b0, 1'b1, "t5");
    check_done("t5");
    check("t5_overrun_set", 32'(overrun), 32'd1);
    ramp_event();
    collect(EVT_LEN, 1'b0, 1'b0, "t5b");
    check_done("t5b");
    check("t5_overrun_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of DRAIN abandons the event.
    do_reset();
    ramp_event();
    collect(5, 1'b0, 1'b0, "t6");
    exp_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_valid_clr", 32'(out_valid), 32'd0);
    check("t6_data_clr", 32'(out_data), 32'd0);
    check("t6_state", 32'(dbg_state), 32'(ST_FILL));
    check("t6_busy", 32'(busy), 32'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_beats", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    drive(0, 1'b1);
    drive(0, 1'b1);
    drive(0, 1'b1);
    drive(150, 1'b1);
    check("t6_fill4_notrig", 32'(busy), 32'd0);
    check("t6_fill4_armed", 32'(dbg_state), 32'(ST_ARMED));
    drive(50, 1'b1);
    drive(150, 1'b1);
    check("t6_trig", 32'(busy), 32'd1);
    for (int k = 1; k <= 8; k++) drive(150 + k, 1'b1);
    exp_q = '{DW'(0), DW'(0), DW'(150), DW'(50), DW'(150), DW'(151), DW'(152),
              DW'(153), DW'(154), DW'(155), DW'(156), DW'(157), DW'(158)};
    collect(EVT_LEN, 1'b0, 1'b0, "t6b");
    check_done("t6b");
    check("t6_overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
